// File: rtl/cle_seq_decoder.sv
// Serial-ROM unlock decoder: a nibble key sequence on strobed bus reads unlocks the
// block, after which each read shifts out one bit of a fixed ID word, LSB first.
module cle_seq_decoder #(
  parameter int                         NIB_W      = 4,
  parameter int                         KEY_LEN    = 4,
  parameter logic [KEY_LEN*NIB_W-1:0]   KEY        = 16'h2AB9,
  parameter int                         ID_W       = 16,
  parameter logic [ID_W-1:0]            ID_VALUE   = 16'hC36A,
  parameter int                         MAX_FAIL   = 3,
  parameter logic [NIB_W-1:0]           RELOCK_NIB = 4'hF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     SSER,
  input  logic                     BA13,
  input  logic                     BA12,
  input  logic [NIB_W-1:0]         BA,
  input  logic                     BR_W,
  input  logic                     BSTB,
  input  logic                     oe,
  output logic                     SDRD,
  output logic                     SDRD_OE,
  output logic [1:0]               q_state,
  output logic                     unlocked,
  output logic [$clog2(ID_W)-1:0]  bit_idx
);

  localparam int K_W  = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int F_W  = $clog2(MAX_FAIL + 1);
  localparam int BI_W = $clog2(ID_W);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MATCH    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [K_W-1:0]    k_r, k_s;
  logic [F_W-1:0]    fail_r, fail_s;
  logic [BI_W-1:0]   bit_idx_r, bit_idx_s;
  logic              bstb_q_r;
  logic              sdrd_hold_r;
  logic              sel_s, ev_s, sdrd_oe_s, fail_inc_s;

  // Key nibble idx, counted from the most-significant end of KEY.
  function automatic logic [NIB_W-1:0] key_nib(input int idx);
    return KEY[(KEY_LEN-1-idx)*NIB_W +: NIB_W];
  endfunction

  assign sel_s     = ~SSER & ~BA13 & BA12 & BR_W;
  assign ev_s      = sel_s & BSTB & ~bstb_q_r;
  assign sdrd_oe_s = sel_s & BSTB & (state_r == UNLOCKED) & (BA != RELOCK_NIB) & ~rst;

  // State register and strobe-edge history; bstb_q resets high so a held strobe cannot fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      k_r         <= '0;
      fail_r      <= '0;
      bit_idx_r   <= '0;
      bstb_q_r    <= 1'b1;
      sdrd_hold_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      k_r       <= k_s;
      fail_r    <= fail_s;
      bit_idx_r <= bit_idx_s;
      bstb_q_r  <= BSTB;
      if (ev_s) begin
        sdrd_hold_r <= sdrd_oe_s & ID_VALUE[bit_idx_r];
      end
    end
  end

  // Next-state logic; only an ev cycle moves anything.
  always_comb begin
    state_s    = state_r;
    k_s        = k_r;
    fail_s     = fail_r;
    bit_idx_s  = bit_idx_r;
    fail_inc_s = 1'b0;
    if (ev_s) begin
      case (state_r)
        IDLE: begin
          if (BA == key_nib(0)) begin
            k_s     = (KEY_LEN == 1) ? '0 : K_W'(1);
            state_s = (KEY_LEN == 1) ? UNLOCKED : MATCH;
          end else begin
            state_s = IDLE;
          end
        end
        MATCH: begin
          if (BA == key_nib(int'(k_r))) begin
            if (k_r == K_W'(KEY_LEN - 1)) begin
              state_s   = UNLOCKED;
              k_s       = '0;
              fail_s    = '0;
              bit_idx_s = '0;
            end else begin
              k_s = k_r + K_W'(1);
            end
          end else begin
            fail_inc_s = 1'b1;
            fail_s     = (fail_r == F_W'(MAX_FAIL)) ? fail_r : fail_r + F_W'(1);
            if (fail_s >= F_W'(MAX_FAIL)) begin
              state_s = LOCKOUT;
              k_s     = '0;
            end else if (BA == key_nib(0)) begin
              state_s = MATCH;
              k_s     = K_W'(1);
            end else begin
              state_s = IDLE;
              k_s     = '0;
            end
          end
        end
        UNLOCKED: begin
          if (BA == RELOCK_NIB) begin
            state_s = IDLE;
            k_s     = '0;
          end else begin
            bit_idx_s = (bit_idx_r == BI_W'(ID_W - 1)) ? '0 : bit_idx_r + BI_W'(1);
          end
        end
        LOCKOUT: begin
          state_s = LOCKOUT;
        end
        default: begin
          state_s = IDLE;
          k_s     = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // While a strobe is held past its ev cycle, the bit captured at ev is replayed.
  assign SDRD_OE  = sdrd_oe_s;
  assign SDRD     = sdrd_oe_s & (ev_s ? ID_VALUE[bit_idx_r] : sdrd_hold_r);
  assign q_state  = oe ? 2'd0 : state_r;
  assign unlocked = (state_r == UNLOCKED) & ~rst;
  assign bit_idx  = bit_idx_r;

endmodule
